prbs_req_arbiter: RTL

- Shares one PRBS bit source between NUM_REQ requesters, e.g. per-agent infection and recovery draws in the disease model.
- Handles seeding and warm-up of the source. Collects WORD_W successive random bits per grant and returns the word to the selected requester.
- Arbitration is round-robin so no requester starves.
- Sits between the per-agent update logic and the random source.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_bit_gen.sv | 27 ++
 rtl/prbs_req_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the PRBS request arbiter.
package prbs_pkg;
    localparam int LFSR_W = 32;
    localparam int TAP_A  = 32;
    localparam int TAP_B  = 22;
    localparam int TAP_C  = 2;
    localparam int TAP_D  = 1;

    localparam logic [LFSR_W-1:0] LOCKUP_SEED = 32'hFFFF_FFFF;
    localparam logic [LFSR_W-1:0] LOCKUP_SUB  = 32'hFFFF_FFFE;
    localparam logic [LFSR_W-1:0] THRESH      = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, SEED, WARMUP, ARB, COLLECT, DELIVER} state_e;

    // Tap numbers are 1-based LFSR bit positions; XNOR feedback enters bit 1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ~(s[TAP_A-1] ^ s[TAP_B-1] ^ s[TAP_C-1] ^ s[TAP_D-1])};
    endfunction
endpackage

// File: rtl/prbs_bit_gen.sv
// 32-bit XNOR Fibonacci LFSR with a registered threshold output bit.
module prbs_bit_gen
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              bit_o
);
    logic [LFSR_W-1:0] state_q;
    logic              bit_q;

    // All-ones is the XNOR lock-up state, so it is never allowed into the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            bit_q   <= 1'b0;
        end else begin
            if (load_i) state_q <= (seed_i == LOCKUP_SEED) ? LOCKUP_SUB : seed_i;
            else        state_q <= lfsr_next(state_q);
            bit_q <= (state_q >= THRESH);
        end
    end

    assign bit_o = bit_q;
endmodule

// File: rtl/prbs_req_arbiter.sv
// Round-robin sharing of one PRBS bit source: seeds, warms up, then collects a word per grant.
module prbs_req_arbiter
    import prbs_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WORD_W        = 8,
    parameter int WARMUP_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_value,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt_valid,
    output logic [WORD_W-1:0]  rand_word,
    output logic               busy,
    output logic               ready
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int SUM_W  = IDX_W + 1;
    localparam int CNT_W  = 10;
    localparam int BCNT_W = $clog2(WORD_W + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d, win_q, win_d, pick;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [LFSR_W-1:0]  seed_q;
    logic               ready_q;
    logic               pick_vld;
    logic [SUM_W-1:0]   sum;
    logic               gen_bit;
    logic               deliver_ok;

    // Seed is captured on the pulse so the SEED cycle does not depend on seed_value still being held.
    prbs_bit_gen u_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == SEED),
        .seed_i (seed_q),
        .bit_o  (gen_bit)
    );

    // Lowest offset from rr_q wins; scanning downward lets the nearest hit overwrite.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_q} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            if (req[sum[IDX_W-1:0]]) begin
                pick     = sum[IDX_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign deliver_ok = (state_q == DELIVER) && !seed_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            SEED:    state_d = (WARMUP_CYCLES == 0) ? ARB : WARMUP;
            WARMUP:  if (wcnt_q == CNT_W'(WARMUP_CYCLES - 1)) state_d = ARB;
            ARB:     if (pick_vld) state_d = COLLECT;
            COLLECT: if (bcnt_q == BCNT_W'(WORD_W - 1)) state_d = DELIVER;
            DELIVER: state_d = ARB;
            default: state_d = IDLE;
        endcase
        // A seed pulse pre-empts everything, including an in-flight word.
        if (seed_load) state_d = SEED;
    end

    always_comb begin
        gnt_valid = '0;
        rand_word = '0;
        busy      = (state_q != ARB);
        ready     = ready_q;
        if (deliver_ok) begin
            gnt_valid[win_q] = 1'b1;
            rand_word        = shift_q;
        end
    end

    always_comb begin
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        win_d   = win_q;
        rr_d    = rr_q;
        case (state_q)
            SEED:    wcnt_d = '0;
            WARMUP:  wcnt_d = wcnt_q + 1'b1;
            ARB: if (pick_vld) begin
                win_d  = pick;
                bcnt_d = '0;
            end
            COLLECT: begin
                shift_d = (shift_q << 1) | WORD_W'(gen_bit);
                bcnt_d  = bcnt_q + 1'b1;
            end
            DELIVER: if (deliver_ok) rr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            win_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            seed_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            win_q   <= win_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            if (seed_load) seed_q <= seed_value;
            if (ready_q) ready_q <= !seed_load;
            else         ready_q <= (state_d == ARB);
        end
    end
endmodule
